sdram_cmd_arbiter: RTL
======================

# sdram_cmd_arbiter

Command-bus scheduler for the SDRAM controller. Generates periodic auto-refresh demands from an internal interval timer. Arbitrates the single SDRAM command path between the auto-refresh engine and the write and read sequencers, issuing one-cycle start pulses to each. Sits above the refresh, write and read state machines; those blocks own the actual command and address sequencing.

## Interface
- REF_PERIOD, 780: refresh interval in Clk cycles (15.6 us at 50 MHz); legal range 4..65535.
- DEBT_MAX, 3: maximum outstanding refreshes tracked; legal range 1..7.
- Clk  input  1  system clock, all logic on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- init_done  input  1  level, SDRAM power-up init complete; arbiter is inert while low.
- ref_done  input  1  one-cycle pulse from refresh engine, refresh sequence finished.
- wr_req  input  1  level, write sequencer requests the bus; held until granted.
- wr_done  input  1  one-cycle pulse, write burst finished.
- rd_req  input  1  level, read sequencer requests the bus; held until granted.
- rd_done  input  1  one-cycle pulse, read burst finished.
- ref_en  output  1  one-cycle pulse, start one auto-refresh sequence.
- wr_en  output  1  one-cycle pulse, start write sequence.
- rd_en  output  1  one-cycle pulse, start read sequence.
- busy  output  1  high whenever state is not IDLE.
- ref_debt  output  3  outstanding refresh count.
- ref_overflow  output  1  sticky, a refresh demand was lost.

## Operation
- States: IDLE, AREF, WRITE, READ. Reset: state IDLE; all outputs 0; interval timer 0; last_grant = READ (so first tie goes to write).
- Interval timer: held at 0 while init_done low. Otherwise counts 0..REF_PERIOD-1 and wraps. The wrap cycle is the terminal count (tc).
- Debt on tc: if ref_debt < DEBT_MAX, increment. Else saturate and set ref_overflow. ref_overflow clears only on Rst.
- IDLE, priority 1: if init_done and ref_debt != 0, go to AREF, pulse ref_en, decrement ref_debt.
- IDLE, priority 2: else if init_done and exactly one of wr_req/rd_req is high, grant it: go to WRITE/READ, pulse wr_en/rd_en, update last_grant.
- IDLE, tie: both wr_req and rd_req high → grant the one opposite last_grant (alternation).
- AREF: wait for ref_done, then IDLE.
- WRITE: wait for wr_done, then IDLE. READ: wait for rd_done, then IDLE.
- Done pulses arriving in a non-matching state are ignored.
- Refresh preempts nothing in flight: debt accrued during WRITE/READ is served at the next IDLE, ahead of pending data requests.
- tc coinciding with a refresh grant: ref_debt net unchanged (+1 −1). Overflow is evaluated against the pre-decrement value.
- init_done dropping while busy: finish current state normally, then stay in IDLE. Timer clears to 0; debt is held.

## Timing
- All outputs registered. A grant pulse is high exactly one cycle: the first cycle the new state is visible.
- Decision latency: a request or debt sampled in IDLE at edge N produces its pulse and new state after edge N. Minimum one cycle from request to pulse.
- Done → IDLE at the next edge. A new grant can issue the edge after that, so back-to-back grants are spaced at least 2 cycles.
- ref_debt and ref_overflow update on the edge following tc.
- Rst asserted mid-operation: immediate return to reset values. In-flight sequencers are reset by the same Rst.

## Test plan
- Refresh cadence: REF_PERIOD=8, init_done=1, no data requests, ref_done returned 3 cycles after each ref_en → ref_en pulses every 8 cycles; ref_debt returns to 0 after each grant.
- Alternation: wr_req and rd_req held high, done pulses returned 2 cycles after each grant → grants go wr, rd, wr, rd; each pulse is exactly 1 cycle wide.
- Refresh priority: a tc occurs during a WRITE, with rd_req high → after wr_done, ref_en is granted before rd_en.
- Debt saturation: DEBT_MAX=3, ref_done withheld for 40 cycles with REF_PERIOD=8 → ref_debt saturates at 3; ref_overflow sets and stays 1 after debt drains.
- Simultaneous tc and refresh grant: ref_debt=1 in IDLE on the tc cycle → ref_en pulses; ref_debt stays 1.
- Reset/init: Rst pulsed while in READ → outputs 0 and state IDLE immediately. With init_done=0 for 50 cycles, no pulses occur and ref_debt stays 0.

Source files
------------

// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: SDRAM command-bus scheduler.
// Refresh interval timer, refresh debt, refresh/write/read grants.
module sdram_cmd_arbiter #(
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned DEBT_MAX   = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       init_done,
  input  logic       ref_done,
  input  logic       wr_req,
  input  logic       wr_done,
  input  logic       rd_req,
  input  logic       rd_done,
  output logic       ref_en,
  output logic       wr_en,
  output logic       rd_en,
  output logic       busy,
  output logic [2:0] ref_debt,
  output logic       ref_overflow
);

  localparam int unsigned TW = $clog2(REF_PERIOD);
  localparam logic [TW-1:0] TC_VAL = TW'(REF_PERIOD - 1);
  localparam logic [2:0] DMAX = 3'(DEBT_MAX);

  typedef enum logic [1:0] {
    IDLE,
    AREF,
    WRITE,
    READ
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic          tc;
  logic          last_rd;
  logic          last_rd_nx;
  logic          idle_ok;
  logic          ref_go;
  logic          wr_go;
  logic          rd_go;
  logic          ref_en_nx;
  logic          wr_en_nx;
  logic          rd_en_nx;
  logic          debt_sat;
  logic          debt_inc;
  logic          ovf_set;
  logic [2:0]    debt_nx;

  assign tc = init_done && (timer == TC_VAL);

  // Refresh interval timer; parked at zero until init completes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      timer <= '0;
    end else if (!init_done || tc) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Grant conditions; refresh debt beats data, ties alternate.
  always_comb begin
    idle_ok = (state == IDLE) && init_done;
    ref_go  = idle_ok && (ref_debt != 3'd0);
    wr_go   = idle_ok && !ref_go && wr_req &&
              (!rd_req || last_rd);
    rd_go   = idle_ok && !ref_go && rd_req &&
              (!wr_req || !last_rd);
  end

  // Debt bookkeeping; saturation judged on the pre-decrement value.
  always_comb begin
    debt_sat = (ref_debt >= DMAX);
    debt_inc = tc && !debt_sat;
    ovf_set  = tc && debt_sat;
    debt_nx  = ref_debt + {2'b00, debt_inc}
                        - {2'b00, ref_go};
  end

  // Next state and next-cycle grant pulses.
  always_comb begin
    state_nx   = state;
    last_rd_nx = last_rd;
    ref_en_nx  = 1'b0;
    wr_en_nx   = 1'b0;
    rd_en_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          ref_go: begin
            state_nx  = AREF;
            ref_en_nx = 1'b1;
          end
          wr_go: begin
            state_nx   = WRITE;
            wr_en_nx   = 1'b1;
            last_rd_nx = 1'b0;
          end
          rd_go: begin
            state_nx   = READ;
            rd_en_nx   = 1'b1;
            last_rd_nx = 1'b1;
          end
          default: ;
        endcase
      end
      AREF: begin
        if (ref_done) state_nx = IDLE;
      end
      WRITE: begin
        if (wr_done) state_nx = IDLE;
      end
      READ: begin
        if (rd_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, grant pulses and debt registers.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      last_rd      <= 1'b1;
      ref_en       <= 1'b0;
      wr_en        <= 1'b0;
      rd_en        <= 1'b0;
      busy         <= 1'b0;
      ref_debt     <= 3'd0;
      ref_overflow <= 1'b0;
    end else begin
      state    <= state_nx;
      last_rd  <= last_rd_nx;
      ref_en   <= ref_en_nx;
      wr_en    <= wr_en_nx;
      rd_en    <= rd_en_nx;
      busy     <= (state_nx != IDLE);
      ref_debt <= debt_nx;
      if (ovf_set) ref_overflow <= 1'b1;
    end
  end

endmodule
